hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core.
- Produces the stall, flush and bubble controls that the IF/ID and ID/EX pipeline registers consume, including IDEXMux:
  - IDEXMux=0: ID/EX latches data fields but zeroes all control fields (bubble).
  - IDEXMux=1: normal pass-through.
- Detects load-use and jr/jalr RAW hazards, taken branches resolved in EX, and ID-stage jumps/exceptions.
- Runs a MEM-stage wait FSM that freezes the whole pipeline on slow memory, with a timeout and saturating performance counters.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/sat_counter.sv | 26 ++
 rtl/hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: PCSrc encodings
// driven by the decoder, and the MEM-wait FSM state type.
package hazard_pkg;

  // PCSrc encodings as produced by the control unit
  localparam logic [2:0] PCSRC_NEXT  = 3'd0;
  localparam logic [2:0] PCSRC_BR    = 3'd1;
  localparam logic [2:0] PCSRC_J     = 3'd2;
  localparam logic [2:0] PCSRC_JR    = 3'd3;
  localparam logic [2:0] PCSRC_ILLOP = 3'd4;
  localparam logic [2:0] PCSRC_XADR  = 3'd5;

  // MEM-stage wait tracking: RUN while memory keeps up, MEMWAIT while held
  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts qualifying cycles and sticks at all-ones
// instead of wrapping, so a long run never reads back as a small number.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);
  localparam logic [W-1:0] MAX = '1;

  // Count up on inc, hold at MAX once reached
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core. Resolves load-use
// and jr/jalr RAW stalls, EX-resolved taken branches, ID-stage jumps and
// exceptions, and freezes the whole pipeline while the MEM stage waits on
// slow memory. A small FSM tracks wait length for the timeout flag; the
// pipeline controls themselves are purely combinational.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic [2:0]       ID_PCSrc,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_WriteReg,
  input  logic [2:0]       EX_PCSrc,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_WriteReg,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXMux,
  output logic             PipeHold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] hold_cnt
);

  // Wait counter must be able to hold MEM_TIMEOUT itself
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  // ---------------------------------------------------------------------
  // Hazard terms; register $0 is hardwired so it never creates a hazard
  // ---------------------------------------------------------------------
  logic hold, lu, jrh, br, jmp;
  logic ex_dst_valid, mem_dst_valid;

  assign ex_dst_valid  = (EX_WriteReg != 5'd0);
  assign mem_dst_valid = (MEM_WriteReg != 5'd0);

  assign hold = mem_req & ~mem_ready;

  assign lu = EX_MemRead & ex_dst_valid &
              ((EX_WriteReg == ID_Rs) | (ID_UsesRt & (EX_WriteReg == ID_Rt)));

  // jr/jalr read rs in ID, so both an ALU result still in EX and a load
  // still in MEM are too late to be forwarded into the jump target.
  assign jrh = (ID_PCSrc == PCSRC_JR) &
               ((EX_RegWrite & ex_dst_valid & (EX_WriteReg == ID_Rs)) |
                (MEM_MemRead & mem_dst_valid & (MEM_WriteReg == ID_Rs)));

  assign br = (EX_PCSrc == PCSRC_BR) & EX_BranchTaken;

  assign jmp = (ID_PCSrc == PCSRC_J) | (ID_PCSrc == PCSRC_ILLOP) |
               (ID_PCSrc == PCSRC_XADR) | ((ID_PCSrc == PCSRC_JR) & ~jrh);

  // ---------------------------------------------------------------------
  // Pipeline controls by priority: hold > branch > stall > jump
  // ---------------------------------------------------------------------
  logic do_stall, do_flush;

  // Decode pipeline enables/flush/bubble and the per-cycle event strobes
  always_comb begin
    // NOTE: every output gets a default before the priority chain so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXMux   = 1'b1;
    PipeHold  = 1'b0;
    do_stall  = 1'b0;
    do_flush  = 1'b0;
    if (reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXMux   = 1'b0;
    end else if (hold) begin
      // Freeze everything; a pending branch or load-use is simply
      // re-evaluated on the cycle memory releases the pipeline.
      PipeHold  = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (br) begin
      // The branch target wins; the ID instruction is squashed anyway,
      // so any stall it would have requested is irrelevant.
      IFIDFlush = 1'b1;
      IDEXMux   = 1'b0;
      do_flush  = 1'b1;
    end else if (lu || jrh) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXMux   = 1'b0;
      do_stall  = 1'b1;
    end else if (jmp) begin
      IFIDFlush = 1'b1;
      do_flush  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // MEM wait FSM: only measures wait length, never drives the controls
  // ---------------------------------------------------------------------
  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              timeout_next;

  // State, wait counter and sticky timeout registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_next;
      mem_timeout <= timeout_next;
    end
  end

  // Next-state, wait count and timeout detection
  always_comb begin
    state_next   = state;
    wait_next    = wait_cnt;
    timeout_next = mem_timeout;
    unique case (state)
      RUN: begin
        if (hold) begin
          state_next = MEMWAIT;
          wait_next  = WAIT_ONE;
        end
      end
      MEMWAIT: begin
        if (hold) begin
          if (wait_cnt != WAIT_MAX) begin
            wait_next = wait_cnt + WAIT_ONE;
          end
        end else begin
          state_next = RUN;
          wait_next  = '0;
        end
      end
      default: begin
        state_next = RUN;
        wait_next  = '0;
      end
    endcase
    // Flag is raised the cycle the count reaches the limit and sticks
    if (hold && (wait_next == WAIT_MAX)) begin
      timeout_next = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (do_stall),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (do_flush),
    .q     (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hold),
    .q     (hold_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share all inputs: a
// main one with wide counters and a short memory timeout, and a second one
// with 2-bit counters to exercise counter saturation.
module tb_hazard_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 8;
  localparam int CW_S = 2;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_wr, mem_wr;
  logic       id_uses_rt, ex_memread, ex_regwrite, ex_bt, mem_memread;
  logic [2:0] id_pcsrc, ex_pcsrc;
  logic       mem_req, mem_ready;

  logic          pc_write, ifid_write, ifid_flush, idex_mux, pipe_hold, mem_to;
  logic [CW-1:0] stall_cnt, flush_cnt, hold_cnt;
  logic          s_pc_write, s_ifid_write, s_ifid_flush, s_idex_mux, s_pipe_hold, s_mem_to;
  logic [CW_S-1:0] s_stall_cnt, s_flush_cnt, s_hold_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset),
    .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt), .ID_PCSrc(id_pcsrc),
    .EX_MemRead(ex_memread), .EX_RegWrite(ex_regwrite), .EX_WriteReg(ex_wr),
    .EX_PCSrc(ex_pcsrc), .EX_BranchTaken(ex_bt),
    .MEM_MemRead(mem_memread), .MEM_WriteReg(mem_wr),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .PCWrite(pc_write), .IFIDWrite(ifid_write), .IFIDFlush(ifid_flush),
    .IDEXMux(idex_mux), .PipeHold(pipe_hold), .mem_timeout(mem_to),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt)
  );

  hazard_ctrl #(.CNT_W(CW_S), .MEM_TIMEOUT(TO)) u_sat (
    .clk(clk), .reset(reset),
    .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt), .ID_PCSrc(id_pcsrc),
    .EX_MemRead(ex_memread), .EX_RegWrite(ex_regwrite), .EX_WriteReg(ex_wr),
    .EX_PCSrc(ex_pcsrc), .EX_BranchTaken(ex_bt),
    .MEM_MemRead(mem_memread), .MEM_WriteReg(mem_wr),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .PCWrite(s_pc_write), .IFIDWrite(s_ifid_write), .IFIDFlush(s_ifid_flush),
    .IDEXMux(s_idex_mux), .PipeHold(s_pipe_hold), .mem_timeout(s_mem_to),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .hold_cnt(s_hold_cnt)
  );

  // ---------------------------------------------------------------------
  // Reference model: event totals kept as unbounded integers, timeout as
  // the length of the current run of held cycles.
  // ---------------------------------------------------------------------
  int m_stall, m_flush, m_hold, m_run;
  bit m_to;
  bit e_pcw, e_ifw, e_flush, e_mux, e_phold;
  bit c_stall, c_flush, c_hold;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic void model_eval();
    bit h, lu, jrh, br, jmp;
    h   = mem_req && !mem_ready;
    lu  = ex_memread && ex_wr != 0 &&
          (ex_wr == id_rs || (id_uses_rt && ex_wr == id_rt));
    jrh = id_pcsrc == 3 &&
          ((ex_regwrite && ex_wr != 0 && ex_wr == id_rs) ||
           (mem_memread && mem_wr != 0 && mem_wr == id_rs));
    br  = ex_pcsrc == 1 && ex_bt;
    jmp = (id_pcsrc inside {3'd2, 3'd4, 3'd5}) || (id_pcsrc == 3 && !jrh);
    e_pcw = 1; e_ifw = 1; e_flush = 0; e_mux = 1; e_phold = 0;
    c_stall = 0; c_flush = 0; c_hold = h;
    if (reset) begin
      e_pcw = 0; e_ifw = 0; e_flush = 1; e_mux = 0;
    end else if (h) begin
      e_phold = 1; e_pcw = 0; e_ifw = 0;
    end else if (br) begin
      e_flush = 1; e_mux = 0; c_flush = 1;
    end else if (lu || jrh) begin
      e_pcw = 0; e_ifw = 0; e_mux = 0; c_stall = 1;
    end else if (jmp) begin
      e_flush = 1; c_flush = 1;
    end
  endfunction

  // Advance one clock, updating the model with the pre-edge inputs
  task automatic cycle();
    model_eval();
    @(posedge clk);
    if (reset) begin
      m_stall = 0; m_flush = 0; m_hold = 0; m_run = 0; m_to = 0;
    end else begin
      m_stall += int'(c_stall);
      m_flush += int'(c_flush);
      m_hold  += int'(c_hold);
      m_run    = c_hold ? m_run + 1 : 0;
      if (c_hold && m_run >= TO) m_to = 1;
    end
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_pcsrc = 0;
    ex_memread = 0; ex_regwrite = 0; ex_wr = 0; ex_pcsrc = 0; ex_bt = 0;
    mem_memread = 0; mem_wr = 0; mem_req = 0; mem_ready = 0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    idle();
    reset = 1;
    mem_req = 1;  // a pending hold must not show through reset
    cycle();
    #2;
    total++; if ({pc_write, ifid_write, ifid_flush, idex_mux, pipe_hold} !== 5'b00100) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00100",
                      {pc_write, ifid_write, ifid_flush, idex_mux, pipe_hold});
    end
    total++; if ({stall_cnt, flush_cnt, hold_cnt} !== '0 || mem_to !== 1'b0) begin
      bad++; $display("FAIL reset_state: got %0d/%0d/%0d to=%b want 0/0/0 to=0",
                      stall_cnt, flush_cnt, hold_cnt, mem_to);
    end
    reset = 0;
    idle();
    cycle();
  endtask

  task automatic test_load_use();
    idle();
    ex_memread = 1; ex_wr = 8; id_rs = 8;
    model_eval(); #2;
    total++; if ({pc_write, ifid_write, idex_mux} !== 3'b000) begin
      bad++; $display("FAIL lu_rs: got %b want 000", {pc_write, ifid_write, idex_mux});
    end
    cycle();
    idle(); #2;
    total++; if (stall_cnt !== 8'd1 || stall_cnt !== sat(m_stall, CW)) begin
      bad++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt);
    end
    ex_memread = 1; ex_wr = 0; id_rs = 0; #2;
    total++; if ({pc_write, ifid_write, idex_mux} !== 3'b111) begin
      bad++; $display("FAIL lu_r0: got %b want 111", {pc_write, ifid_write, idex_mux});
    end
    ex_wr = 9; id_rs = 3; id_rt = 9; id_uses_rt = 1; #2;
    total++; if (pc_write !== 1'b0 || idex_mux !== 1'b0) begin
      bad++; $display("FAIL lu_rt: got pcw=%b mux=%b want 0 0", pc_write, idex_mux);
    end
    id_uses_rt = 0; #2;
    total++; if (pc_write !== 1'b1) begin
      bad++; $display("FAIL lu_rt_unused: got pcw=%b want 1", pc_write);
    end
    cycle();
  endtask

  task automatic test_jr();
    int f0;
    idle();
    f0 = m_flush;
    id_pcsrc = 3; id_rs = 31; ex_regwrite = 1; ex_wr = 31;
    #2;
    total++; if ({pc_write, ifid_write, ifid_flush, idex_mux} !== 4'b0000) begin
      bad++; $display("FAIL jr_stall: got %b want 0000",
                      {pc_write, ifid_write, ifid_flush, idex_mux});
    end
    cycle();
    ex_regwrite = 0; ex_wr = 0; #2;
    total++; if ({pc_write, ifid_flush, idex_mux} !== 3'b111) begin
      bad++; $display("FAIL jr_go: got %b want 111", {pc_write, ifid_flush, idex_mux});
    end
    cycle();
    #2;
    total++; if (flush_cnt !== sat(f0 + 1, CW)) begin
      bad++; $display("FAIL jr_flush_cnt: got %0d want %0d", flush_cnt, f0 + 1);
    end
    mem_memread = 1; mem_wr = 31; #2;
    total++; if (pc_write !== 1'b0 || ifid_flush !== 1'b0) begin
      bad++; $display("FAIL jr_mem_load: got pcw=%b fl=%b want 0 0", pc_write, ifid_flush);
    end
    cycle();
    idle();
  endtask

  task automatic test_branch_lu();
    int s0;
    idle();
    s0 = m_stall;
    ex_pcsrc = 1; ex_bt = 1; ex_memread = 1; ex_wr = 5; id_rs = 5;
    #2;
    total++; if ({pc_write, ifid_flush, idex_mux} !== 3'b110) begin
      bad++; $display("FAIL br_over_lu: got %b want 110", {pc_write, ifid_flush, idex_mux});
    end
    cycle();
    idle(); #2;
    total++; if (stall_cnt !== sat(s0, CW)) begin
      bad++; $display("FAIL br_stall_cnt: got %0d want %0d", stall_cnt, s0);
    end
    cycle();
  endtask

  task automatic test_mem_wait();
    int h0, held;
    idle();
    h0 = m_hold;
    held = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        mem_req = 1; mem_ready = (i == 3);
        ex_memread = (i == 1); ex_wr = 4; id_rs = 4;  // pending lu is suppressed
        #2;
        if (pipe_hold) held++;
        total++; if (i < 3 && {pipe_hold, pc_write, ifid_write, idex_mux} !== 4'b1001) begin
          bad++; $display("FAIL mem_hold[%0d]: got %b want 1001", i,
                          {pipe_hold, pc_write, ifid_write, idex_mux});
        end
        cycle();
      end
      idle(); cycle();
    end
    #2;
    total++; if (held !== 6 || hold_cnt !== sat(h0 + 6, CW)) begin
      bad++; $display("FAIL mem_hold_cnt: got held=%0d cnt=%0d want 6 %0d",
                      held, hold_cnt, h0 + 6);
    end
    // two separate 3-cycle waits must not add up to a timeout
    total++; if (mem_to !== 1'b0) begin
      bad++; $display("FAIL mem_release: got to=%b want 0", mem_to);
    end
  endtask

  task automatic test_timeout();
    idle();
    for (int i = 0; i < 6; i++) begin
      mem_req = 1; mem_ready = 0; #2;
      total++; if (mem_to !== (i >= TO) || mem_to !== m_to) begin
        bad++; $display("FAIL timeout[%0d]: got %b want %b", i, mem_to, i >= TO);
      end
      cycle();
    end
    idle(); cycle(); #2;
    total++; if (mem_to !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky: got %b want 1", mem_to);
    end
    reset = 1; cycle(); reset = 0; #2;
    total++; if (mem_to !== 1'b0 || hold_cnt !== '0) begin
      bad++; $display("FAIL timeout_clear: got to=%b hold=%0d want 0 0", mem_to, hold_cnt);
    end
  endtask

  task automatic test_saturation();
    idle();
    reset = 1; cycle(); reset = 0;
    for (int i = 0; i < 5; i++) begin
      ex_memread = 1; ex_wr = 12; id_rs = 12;
      cycle();
    end
    idle(); #2;
    total++; if (s_stall_cnt !== 2'd3 || stall_cnt !== 8'd5) begin
      bad++; $display("FAIL sat_stall: got %0d/%0d want 3/5", s_stall_cnt, stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(63) == 0);
      id_rs       = 5'($urandom_range(3));
      id_rt       = 5'($urandom_range(3));
      id_uses_rt  = 1'($urandom);
      id_pcsrc    = 3'($urandom_range(6));
      ex_memread  = 1'($urandom);
      ex_regwrite = 1'($urandom);
      ex_wr       = 5'($urandom_range(3));
      ex_pcsrc    = 3'($urandom_range(3));
      ex_bt       = 1'($urandom);
      mem_memread = 1'($urandom);
      mem_wr      = 5'($urandom_range(3));
      mem_req     = ($urandom_range(2) != 0);
      mem_ready   = ($urandom_range(2) == 0);
      model_eval(); #2;
      total++; if ({pc_write, ifid_write, ifid_flush, idex_mux, pipe_hold} !==
                   {e_pcw, e_ifw, e_flush, e_mux, e_phold}) begin
        bad++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", n,
                        {pc_write, ifid_write, ifid_flush, idex_mux, pipe_hold},
                        {e_pcw, e_ifw, e_flush, e_mux, e_phold});
      end
      total++; if (mem_to !== m_to || s_mem_to !== m_to) begin
        bad++; $display("FAIL rnd_timeout[%0d]: got %b/%b want %b", n, mem_to, s_mem_to, m_to);
      end
      total++; if (stall_cnt !== sat(m_stall, CW) || flush_cnt !== sat(m_flush, CW) ||
                   hold_cnt !== sat(m_hold, CW)) begin
        bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", n,
                        stall_cnt, flush_cnt, hold_cnt,
                        sat(m_stall, CW), sat(m_flush, CW), sat(m_hold, CW));
      end
      total++; if (s_stall_cnt !== sat(m_stall, CW_S) || s_flush_cnt !== sat(m_flush, CW_S) ||
                   s_hold_cnt !== sat(m_hold, CW_S)) begin
        bad++; $display("FAIL rnd_sat_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", n,
                        s_stall_cnt, s_flush_cnt, s_hold_cnt,
                        sat(m_stall, CW_S), sat(m_flush, CW_S), sat(m_hold, CW_S));
      end
      cycle();
    end
    reset = 0;
  endtask

  initial begin
    m_stall = 0; m_flush = 0; m_hold = 0; m_run = 0; m_to = 0;
    idle();
    reset = 1;
    #1;
    cycle();
    test_reset();
    test_load_use();
    test_jr();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
